reg_trace_monitor: RTL and testbench

- Sits directly downstream of the CPU top level.
- Consumes the architectural register taps a0, a1 and t1 and detects every change in their values.
- Queues each change as a tagged entry in a first-word-fall-through FIFO, drained over a valid/ready stream to a UART/display driver or a testbench scoreboard.
- Decouples the single-cycle core from a slower consumer; the core is never stalled.

---
 rtl/reg_trace_pkg.sv | 32 +++
 rtl/trace_fifo.sv | 67 ++++++
 rtl/reg_trace_monitor.sv | 180 ++++++++++++++++++
 tb/tb_reg_trace_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_trace_pkg.sv
// rtl/reg_trace_pkg.sv - shared types for the register trace monitor (REG_TRACE_TIMESTAMP_EN adds ts)
package reg_trace_pkg;

    localparam int NUM_SRC          = 3;
    localparam int TRACE_DATA_WIDTH = 32;
    localparam int TS_WIDTH         = 32;

    typedef enum logic [1:0] {
        SRC_A0 = 2'd0,
        SRC_A1 = 2'd1,
        SRC_T1 = 2'd2
    } trace_src_e;

    // Entry at the default data width; the top rebuilds the same layout at DATA_WIDTH.
    typedef struct packed {
        trace_src_e                  src;
        logic [TRACE_DATA_WIDTH-1:0] data;
`ifdef REG_TRACE_TIMESTAMP_EN
        logic [TS_WIDTH-1:0]         ts;
`endif
    } trace_entry_t;

    // Round-robin successor in the fixed order a0 -> a1 -> t1 -> a0.
    function automatic trace_src_e next_src(trace_src_e s);
        case (s)
            SRC_A0:  return SRC_A1;
            SRC_A1:  return SRC_T1;
            default: return SRC_A0;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through FIFO for trace entries
module trace_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = reg_trace_pkg::trace_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic                     empty_o,
    output entry_t                   head_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = count_q;

    // Next-state pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/reg_trace_monitor.sv
// rtl/reg_trace_monitor.sv - logs a0/a1/t1 value changes into a FWFT stream (REG_TRACE_TIMESTAMP_EN adds ts_o)
module reg_trace_monitor
    import reg_trace_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     a0_i,
    input  logic [DATA_WIDTH-1:0]     a1_i,
    input  logic [DATA_WIDTH-1:0]     t1_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [1:0]                out_src_o,
    output logic [DATA_WIDTH-1:0]     out_data_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic [CNT_WIDTH-1:0]      coalesced_o
`ifdef REG_TRACE_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0]       ts_o
`endif
);

    // Same layout as trace_entry_t, sized by this instance's DATA_WIDTH.
    typedef struct packed {
        trace_src_e              src;
        logic [DATA_WIDTH-1:0]   data;
`ifdef REG_TRACE_TIMESTAMP_EN
        logic [TS_WIDTH-1:0]     ts;
`endif
    } entry_t;

    logic [DATA_WIDTH-1:0]   tap        [NUM_SRC];
    logic [DATA_WIDTH-1:0]   prev_q     [NUM_SRC];
    logic [DATA_WIDTH-1:0]   prev_d     [NUM_SRC];
    logic [DATA_WIDTH-1:0]   pend_val_q [NUM_SRC];
    logic [DATA_WIDTH-1:0]   pend_val_d [NUM_SRC];
    logic [NUM_SRC-1:0]      pend_q, pend_d;
    trace_src_e              rr_q, rr_d;
    logic [CNT_WIDTH-1:0]    coal_q, coal_d;

    trace_src_e              grant_idx;
    trace_src_e              search_idx;
    logic                    grant_vld;
    logic [1:0]              ovw_cnt;
    logic [CNT_WIDTH:0]      coal_sum;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    can_grant;
    entry_t                  push_entry;
    entry_t                  head;

`ifdef REG_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]     ts_cnt_q;
    logic [TS_WIDTH-1:0]     pend_ts_q [NUM_SRC];
    logic [TS_WIDTH-1:0]     pend_ts_d [NUM_SRC];
`endif

    assign tap[SRC_A0] = a0_i;
    assign tap[SRC_A1] = a1_i;
    assign tap[SRC_T1] = t1_i;

    assign fifo_pop  = out_valid_o && out_ready_i;
    assign can_grant = !fifo_full || fifo_pop;

    // Round-robin search from the pointer; one grant per edge, only when there is room.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = rr_q;
        search_idx = rr_q;
        rr_d       = rr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_vld && can_grant && pend_q[search_idx]) begin
                grant_vld = 1'b1;
                grant_idx = search_idx;
            end
            search_idx = next_src(search_idx);
        end
        if (grant_vld) rr_d = next_src(grant_idx);
    end

    // Change detection and pending update; a granted source that changes again stays pending without coalescing.
    always_comb begin
        pend_d  = pend_q;
        ovw_cnt = 2'd0;
        for (int s = 0; s < NUM_SRC; s++) begin
            prev_d[s]     = prev_q[s];
            pend_val_d[s] = pend_val_q[s];
`ifdef REG_TRACE_TIMESTAMP_EN
            pend_ts_d[s]  = pend_ts_q[s];
`endif
            if (grant_vld && (grant_idx == trace_src_e'(s))) pend_d[s] = 1'b0;
            if (tap[s] != prev_q[s]) begin
                prev_d[s]     = tap[s];
                pend_val_d[s] = tap[s];
`ifdef REG_TRACE_TIMESTAMP_EN
                pend_ts_d[s]  = ts_cnt_q;
`endif
                if (pend_q[s] && !(grant_vld && (grant_idx == trace_src_e'(s))))
                    ovw_cnt = ovw_cnt + 2'd1;
                pend_d[s] = 1'b1;
            end
        end
        coal_sum = {1'b0, coal_q} + (CNT_WIDTH+1)'(ovw_cnt);
        coal_d   = coal_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : coal_sum[CNT_WIDTH-1:0];
    end

    // Entry presented to the FIFO for the granted source.
    always_comb begin
        push_entry      = '0;
        push_entry.src  = grant_idx;
        push_entry.data = pend_val_q[grant_idx];
`ifdef REG_TRACE_TIMESTAMP_EN
        push_entry.ts   = pend_ts_q[grant_idx];
`endif
    end

    // Tracking state: last seen values, pending slots, arbiter pointer and overwrite counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                prev_q[s]     <= '0;
                pend_val_q[s] <= '0;
            end
            pend_q <= '0;
            rr_q   <= SRC_A0;
            coal_q <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                prev_q[s]     <= prev_d[s];
                pend_val_q[s] <= pend_val_d[s];
            end
            pend_q <= pend_d;
            rr_q   <= rr_d;
            coal_q <= coal_d;
        end
    end

`ifdef REG_TRACE_TIMESTAMP_EN
    // Free-running cycle counter and the per-source capture of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt_q <= '0;
            for (int s = 0; s < NUM_SRC; s++) pend_ts_q[s] <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            for (int s = 0; s < NUM_SRC; s++) pend_ts_q[s] <= pend_ts_d[s];
        end
    end
`endif

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (grant_vld),
        .push_data_i (push_entry),
        .full_o      (fifo_full),
        .pop_i       (fifo_pop),
        .empty_o     (fifo_empty),
        .head_o      (head),
        .level_o     (level_o)
    );

    // Head fields are forced to zero when empty so stale storage never shows.
    assign out_valid_o = !fifo_empty;
    assign out_src_o   = out_valid_o ? head.src  : 2'd0;
    assign out_data_o  = out_valid_o ? head.data : '0;
    assign coalesced_o = coal_q;
`ifdef REG_TRACE_TIMESTAMP_EN
    assign ts_o        = out_valid_o ? head.ts   : '0;
`endif

endmodule

// File: tb/tb_reg_trace_monitor.sv
// tb/tb_reg_trace_monitor.sv - self-checking bench for reg_trace_monitor
module tb_reg_trace_monitor;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a0 = '0, a1 = '0, t1 = '0;
    logic        rdy = 1'b0;
    logic        out_valid;
    logic [1:0]  out_src;
    logic [31:0] out_data;
    logic [4:0]  level;
    logic [15:0] coalesced;
`ifdef REG_TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_trace_monitor #(.DEPTH(DEPTH), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .a0_i        (a0),
        .a1_i        (a1),
        .t1_i        (t1),
        .out_valid_o (out_valid),
        .out_ready_i (rdy),
        .out_src_o   (out_src),
        .out_data_o  (out_data),
        .level_o     (level),
        .coalesced_o (coalesced)
`ifdef REG_TRACE_TIMESTAMP_EN
        ,
        .ts_o        (ts)
`endif
    );

    // Reference: per-source pending slot plus a plain queue of logged entries.
    typedef struct { int src; logic [31:0] data; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_prev[3];
    logic [31:0] m_pval[3];
    bit          m_pend[3];
    int          m_rr;
    int          m_coal;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int s = 0; s < 3; s++) begin
            m_prev[s] = '0; m_pval[s] = '0; m_pend[s] = 0;
        end
        m_rr = 0;
        m_coal = 0;
    endtask

    task automatic model_update();
        logic [31:0] t[3];
        bit pop, room;
        int g;
        t[0] = a0; t[1] = a1; t[2] = t1;
        pop  = (m_q.size() != 0) && rdy;
        room = (m_q.size() < DEPTH) || pop;
        g = -1;
        if (room)
            for (int k = 0; k < 3; k++)
                if (g < 0 && m_pend[(m_rr + k) % 3]) g = (m_rr + k) % 3;
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back('{g, m_pval[g]});
            m_pend[g] = 0;
            m_rr = (g + 1) % 3;
        end
        for (int s = 0; s < 3; s++) begin
            if (t[s] != m_prev[s]) begin
                if (m_pend[s] && m_coal != 16'hFFFF) m_coal++;
                m_pend[s] = 1;
                m_pval[s] = t[s];
                m_prev[s] = t[s];
            end
        end
    endtask

    task automatic model_check();
        chk("valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("level", 64'(level), 64'(m_q.size()));
        chk("coalesced", 64'(coalesced), 64'(m_coal));
        if (m_q.size() != 0) begin
            chk("src", 64'(out_src), 64'(m_q[0].src));
            chk("data", 64'(out_data), 64'(m_q[0].data));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    // Asynchronous reset pulse; outputs must drop before any clock edge.
    task automatic do_reset();
        a0 = '0; a1 = '0; t1 = '0;
        rst = 1'b1;
        #1;
        chk("rst_valid_now", 64'(out_valid), 64'd0);
        chk("rst_level_now", 64'(level), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] a0, a1, t1;
        logic        rdy;
        logic        ev;
        logic [1:0]  es;
        logic [31:0] ed;
        logic [4:0]  el;
    } vec_t;

    vec_t vt[$];

    initial begin
        int n;
        logic [31:0] got;
        model_reset();

        vt.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{0, 0, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{0, 5, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{0, 5, 0, 0, 1, 1, 0, 5, 1});
        vt.push_back('{0, 5, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{0, 5, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0});
        vt.push_back('{0, 1, 2, 3, 1, 0, 0, 0, 0});
        vt.push_back('{0, 1, 2, 3, 1, 1, 0, 1, 1});
        vt.push_back('{0, 1, 2, 3, 1, 1, 1, 2, 1});
        vt.push_back('{0, 1, 2, 3, 1, 1, 2, 3, 1});
        vt.push_back('{0, 1, 2, 3, 1, 0, 0, 0, 0});

        foreach (vt[i]) begin
            rdy = vt[i].rdy;
            if (vt[i].rst) begin
                do_reset();
            end else begin
                a0 = vt[i].a0; a1 = vt[i].a1; t1 = vt[i].t1;
                step();
            end
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_src", i),   64'(out_src),   64'(vt[i].es));
            chk($sformatf("vec%0d_data", i),  64'(out_data),  64'(vt[i].ed));
            chk($sformatf("vec%0d_level", i), 64'(level),     64'(vt[i].el));
            chk($sformatf("vec%0d_coal", i),  64'(coalesced), 64'd0);
        end

        // Back-pressure: fill to DEPTH, then coalesce the rest into the a1 slot.
        do_reset();
        rdy = 1'b0;
        for (int v = 1; v <= 20; v++) begin
            a1 = 32'(v);
            step();
        end
        chk("fill_level", 64'(level), 64'd16);
        chk("fill_coal", 64'(coalesced), 64'd3);
        chk("fill_head_data", 64'(out_data), 64'd1);
        chk("fill_head_src", 64'(out_src), 64'd1);
        rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            got = out_data;
            step();
            chk($sformatf("drain%0d", i), 64'(got), (i < 16) ? 64'(i + 1) : 64'd20);
            if (i == 0) chk("full_pop_push_level", 64'(level), 64'd16);
        end

        // Async reset while seven entries are queued, then a single t1 change.
        do_reset();
        rdy = 1'b0;
        for (int v = 1; v <= 7; v++) begin
            a0 = 32'(v);
            step();
        end
        step();
        chk("seven_level", 64'(level), 64'd7);
        rdy = 1'b1;
        #3;
        do_reset();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            t1 = 32'h10;
            step();
            if (out_valid) begin
                n++;
                chk("post_rst_src", 64'(out_src), 64'd2);
                chk("post_rst_data", 64'(out_data), 64'h10);
            end
        end
        chk("post_rst_entries", 64'(n), 64'd1);

`ifdef REG_TRACE_TIMESTAMP_EN
        begin
            logic [31:0] ts_seen[$];
            do_reset();
            rdy = 1'b1;
            for (int i = 0; i < 30; i++) begin
                a0 = (i >= 15) ? 32'd2 : 32'd1;
                step();
                if (out_valid) ts_seen.push_back(ts);
            end
            chk("ts_entries", 64'(ts_seen.size()), 64'd2);
            if (ts_seen.size() == 2) chk("ts_delta", 64'(ts_seen[1] - ts_seen[0]), 64'd15);
        end
`endif

        // Randomized traffic with small value ranges so repeats and coalescing occur.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) a0 = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) a1 = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) t1 = 32'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 9) < ((i % 200) < 100 ? 2 : 8));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
